// File: rtl/led_fade_sequencer_if.sv
// Pin-level bundle between the fade sequencer and its controller/LED pins.
// The sequencer uses the slave modport; whoever drives ENABLE/DIR uses master.
interface led_fade_sequencer_if;
  logic       ENABLE;
  logic       DIR;
  logic       LED1;
  logic       LED2;
  logic       LED3;
  logic       LED4;
  logic [1:0] ACTIVE_CH;
  logic       BUSY;

  modport master (
    output ENABLE,
    output DIR,
    input  LED1,
    input  LED2,
    input  LED3,
    input  LED4,
    input  ACTIVE_CH,
    input  BUSY
  );

  modport slave (
    input  ENABLE,
    input  DIR,
    output LED1,
    output LED2,
    output LED3,
    output LED4,
    output ACTIVE_CH,
    output BUSY
  );
endinterface

// File: rtl/led_fade_sequencer.sv
// Four-channel LED fade sequencer: one shared 32-step PWM engine is handed round the
// channels, each ramping up, holding at full, and ramping down before the next takes over.
module led_fade_sequencer #(
  parameter int unsigned PRESCALE    = 128,
  parameter int unsigned STEP_FRAMES = 64,
  parameter int unsigned HOLD_STEPS  = 16
) (
  input logic                 CLK_3p33MHZ,
  input logic                 RESET_N,
  led_fade_sequencer_if.slave bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PW-1:0] PrescLast = PW'(PRESCALE - 1);
  localparam logic [FW-1:0] FrameLast = FW'(STEP_FRAMES - 1);
  localparam logic [HW-1:0] HoldLast  = HW'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRampUp,
    StHold,
    StRampDown,
    StNext
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    pwm_q, pwm_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [4:0]    duty_q, duty_d;
  logic [1:0]    ch_q, ch_d;
  logic [3:0]    led_q, led_d;

  logic running;
  logic tick;
  logic frame_end;
  logic step;

  // Timebase only advances while a channel is fading; NEXT freezes it for one clock so the
  // next channel starts on a clean frame boundary.
  assign running   = (state_q == StRampUp) || (state_q == StHold) || (state_q == StRampDown);
  assign tick      = running && (presc_q == PrescLast);
  assign frame_end = tick && (pwm_q == 5'd31);
  assign step      = frame_end && (frame_q == FrameLast);

  always_comb begin
    presc_d = presc_q;
    pwm_d   = pwm_q;
    frame_d = frame_q;
    if (state_q == StIdle) begin
      presc_d = '0;
      pwm_d   = '0;
      frame_d = '0;
    end else if (running) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        pwm_d = pwm_q + 5'd1;
      end
      if (frame_end) begin
        frame_d = step ? '0 : frame_q + FW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    ch_d    = ch_q;
    unique case (state_q)
      StIdle: begin
        duty_d = '0;
        hold_d = '0;
        if (bus.ENABLE) begin
          state_d = StRampUp;
        end
      end
      StRampUp: begin
        if (step) begin
          if (!bus.ENABLE) begin
            // Stopped before the first increment: nothing to ramp down.
            state_d = (duty_q == 5'd0) ? StNext : StRampDown;
          end else begin
            duty_d = duty_q + 5'd1;
            if (duty_q == 5'd30) begin
              state_d = StHold;
              hold_d  = '0;
            end
          end
        end
      end
      StHold: begin
        if (step) begin
          if (!bus.ENABLE || (hold_q == HoldLast)) begin
            state_d = StRampDown;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      StRampDown: begin
        if (step) begin
          if (duty_q <= 5'd1) begin
            duty_d  = '0;
            state_d = StNext;
          end else begin
            duty_d = duty_q - 5'd1;
          end
        end
      end
      StNext: begin
        ch_d    = bus.DIR ? ch_q - 2'd1 : ch_q + 2'd1;
        state_d = bus.ENABLE ? StRampUp : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    led_d       = '0;
    led_d[ch_q] = (pwm_q < duty_q);
  end

  always_ff @(posedge CLK_3p33MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      presc_q <= '0;
      pwm_q   <= '0;
      frame_q <= '0;
      hold_q  <= '0;
      duty_q  <= '0;
      ch_q    <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      ch_q    <= ch_d;
      led_q   <= led_d;
    end
  end

  assign bus.LED1      = led_q[0];
  assign bus.LED2      = led_q[1];
  assign bus.LED3      = led_q[2];
  assign bus.LED4      = led_q[3];
  assign bus.ACTIVE_CH = ch_q;
  assign bus.BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with a fast timebase (64-clock frames, one frame
// per duty step); per-frame LED high counts are compared against hand-derived duty values.
module tb_led_fade_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  led_fade_sequencer_if bus ();

  led_fade_sequencer #(
    .PRESCALE   (2),
    .STEP_FRAMES(1),
    .HOLD_STEPS (2)
  ) dut (
    .CLK_3p33MHZ(clk),
    .RESET_N    (rst_n),
    .bus        (bus)
  );

  logic [3:0] leds;
  assign leds = {bus.LED4, bus.LED3, bus.LED2, bus.LED1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called just after the edge that starts RAMP_UP on channel ch. Frame k covers the 64
  // samples after that edge (LED output lags the PWM compare by one clock).
  task automatic run_channel(input logic [1:0] ch, input logic [1:0] nxt, input bit stop);
    int hi;
    int other;
    int idx;
    int first_hi;
    int d;
    int last_k;
    last_k   = stop ? 20 : 63;
    idx      = 0;
    first_hi = -1;
    for (int k = 0; k <= last_k; k++) begin
      if (stop && k == 10) bus.ENABLE = 1'b0;
      if (stop) d = (k <= 10) ? k : 21 - k;
      else      d = (k <= 31) ? k : ((k <= 33) ? 31 : 64 - k);
      hi    = 0;
      other = 0;
      for (int c = 0; c < 64; c++) begin
        tick();
        idx++;
        if (leds[ch]) begin
          hi++;
          if (first_hi < 0) first_hi = idx;
        end
        other += $countones(leds) - int'(leds[ch]);
      end
      check($sformatf("duty ch%0d frame%0d", ch, k), hi, 2 * d);
      check($sformatf("exclusive ch%0d frame%0d", ch, k), other, 0);
    end
    check($sformatf("first_rise ch%0d", ch), first_hi, 65);
    tick();
    check($sformatf("next_ch from %0d", ch), int'(bus.ACTIVE_CH), int'(nxt));
    check($sformatf("busy_after_next ch%0d", ch), int'(bus.BUSY), stop ? 0 : 1);
    check($sformatf("leds_after_next ch%0d", ch), int'(leds), 0);
  endtask

  initial begin
    int hi;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.ENABLE = 1'b0;
    bus.DIR    = 1'b0;
    repeat (3) tick();
    check("reset leds", int'(leds), 0);
    check("reset active_ch", int'(bus.ACTIVE_CH), 0);
    check("reset busy", int'(bus.BUSY), 0);

    rst_n = 1'b1;
    repeat (5) tick();
    check("idle busy with enable low", int'(bus.BUSY), 0);
    check("idle leds", int'(leds), 0);

    // Start: BUSY one clock after ENABLE is sampled.
    bus.ENABLE = 1'b1;
    tick();
    check("start busy", int'(bus.BUSY), 1);
    check("start active_ch", int'(bus.ACTIVE_CH), 0);

    run_channel(2'd0, 2'd1, 1'b0);
    run_channel(2'd1, 2'd2, 1'b0);
    run_channel(2'd2, 2'd3, 1'b0);
    run_channel(2'd3, 2'd0, 1'b0);

    bus.DIR = 1'b1;
    run_channel(2'd0, 2'd3, 1'b0);

    // Graceful stop while channel 3 is at duty 10 in RAMP_UP.
    run_channel(2'd3, 2'd2, 1'b1);
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      hi += $countones(leds);
    end
    check("idle leds after stop", hi, 0);
    check("idle busy after stop", int'(bus.BUSY), 0);
    check("idle active_ch after stop", int'(bus.ACTIVE_CH), 2);

    // Restart from IDLE.
    bus.ENABLE = 1'b1;
    tick();
    check("restart busy", int'(bus.BUSY), 1);
    check("restart active_ch", int'(bus.ACTIVE_CH), 2);
    run_channel(2'd2, 2'd1, 1'b0);

    // Asynchronous reset in the middle of channel 1's HOLD phase.
    repeat (32 * 64 + 10) tick();
    check("hold led2 high", int'(leds), 4'b0010);
    check("hold busy", int'(bus.BUSY), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset leds", int'(leds), 0);
    check("async reset active_ch", int'(bus.ACTIVE_CH), 0);
    check("async reset busy", int'(bus.BUSY), 0);
    repeat (3) tick();
    rst_n      = 1'b1;
    bus.ENABLE = 1'b0;
    repeat (3) tick();
    check("post reset busy", int'(bus.BUSY), 0);
    check("post reset leds", int'(leds), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_fade_sequencer.md
# led_fade_sequencer

Four-channel LED brightness sequencer built around a shared 32-step PWM engine. It holds one active channel at a time. It ramps that channel's duty cycle up, holds it at full, ramps it down, then hands the PWM engine to the next LED in a rotating sweep. It sits between the board clock and the LED1–LED4 pins and replaces free-running per-LED PWM with one scheduled, glitch-free datapath.

## Interface
- PRESCALE, 128: system clocks per PWM tick (≥2); 128 gives ≈26 kHz ticks at 3.33 MHz.
- STEP_FRAMES, 64: PWM frames (32 ticks each) per duty step (≥1).
- HOLD_STEPS, 16: duty steps spent at full brightness (≥1).
- CLK_3p33MHZ  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  level; high starts or continues sweeping, low requests graceful stop.
- DIR  in  1  sweep direction; 0 = LED1→LED4, 1 = LED4→LED1; sampled in NEXT only.
- LED1, LED2, LED3, LED4  out  1 each  PWM outputs, registered; only active channel may be high.
- ACTIVE_CH  out  2  index of the channel owning the PWM engine (0 = LED1).
- BUSY  out  1  high whenever state ≠ IDLE.

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps. It emits a 1-clock tick when the count equals PRESCALE-1.
- pwm_cnt is 5 bits and increments on tick, wrapping 31→0. A frame_end pulse occurs on the tick where pwm_cnt==31.
- frame_cnt counts frame_end pulses 0..STEP_FRAMES-1. A step pulse occurs on the frame_end where frame_cnt==STEP_FRAMES-1. Step is therefore always coincident with a frame boundary.
- duty is 5 bits, range 0..31. The active LED is driven by (pwm_cnt < duty), so duty 0 means fully off and 31 means 31/32 on. All inactive LEDs are 0.
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN, NEXT.
  - IDLE: duty=0. If ENABLE=1, go to RAMP_UP next clock. Prescaler, pwm_cnt and frame_cnt are cleared while in IDLE, so the first step occurs exactly 32·PRESCALE·STEP_FRAMES clocks after entry.
  - RAMP_UP: on step, duty+1. On the step where duty becomes 31, go to HOLD with hold_cnt=0. On a step with ENABLE=0, go to RAMP_DOWN without incrementing.
  - HOLD: on step, hold_cnt+1. After HOLD_STEPS steps, go to RAMP_DOWN. On a step with ENABLE=0, go to RAMP_DOWN immediately.
  - RAMP_DOWN: on step, duty-1. On the step where duty becomes 0, go to NEXT. ENABLE is ignored here.
  - NEXT: lasts 1 clock. ACTIVE_CH becomes ACTIVE_CH+1 if DIR=0, else ACTIVE_CH-1, mod 4 (3→0 and 0→3 wrap). Go to RAMP_UP if ENABLE=1, else IDLE.
- Duty, state and ACTIVE_CH change only on step or in NEXT/IDLE. A PWM frame is never truncated.
- No arithmetic overflow: duty never increments past 31 or decrements below 0, because transitions occur on reaching those values.

## Timing
- On reset assertion, immediately: LED1..4=0, ACTIVE_CH=0, BUSY=0, state=IDLE, duty=0, and all counters 0. Reset mid-ramp abandons the sweep.
- After reset release, the first clock with ENABLE=1 moves to RAMP_UP. BUSY rises 1 clock after ENABLE is sampled high.
- LED outputs are registered: they reflect (pwm_cnt < duty) with 1-clock latency.
- Full channel cycle = (31 + HOLD_STEPS + 31) steps + 1 clock (NEXT) + 1 clock (IDLE→RAMP_UP, only when starting from IDLE).
- When ENABLE falls: ramp down begins at the next step boundary, the channel reaches 0, ACTIVE_CH advances, and the block returns to IDLE. BUSY falls 1 clock after NEXT.

## Test plan
- Reset: assert RESET_N=0 mid-HOLD with LED2 active → all LEDs 0, ACTIVE_CH=0 and BUSY=0 within the same clock, with no clock edge needed.
- Sweep (PRESCALE=2, STEP_FRAMES=1, HOLD_STEPS=2, DIR=0, ENABLE=1):
  - LED1 high-count per 64-clock frame rises 2,4,…,62 (2 clocks per duty unit), holds at 62 for 2 frames, then falls to 0.
  - ACTIVE_CH then becomes 1 and LED2 begins ramping.
- Wrap: DIR=1 from ACTIVE_CH=0 → after the first channel cycle ACTIVE_CH=3; with DIR=0 from 3 → 0.
- Graceful stop: drop ENABLE at duty=10 in RAMP_UP → duty steps 10→9→…→0, ACTIVE_CH advances by 1, state=IDLE, BUSY=0, and all LEDs stay 0 afterward.
- Exclusivity and glitch-free behaviour: over a full 4-channel sweep, never more than one LED is high in any clock. Duty changes only on clocks where pwm_cnt has just wrapped to 0.
- Restart: re-assert ENABLE in IDLE → BUSY=1 after 1 clock and the first duty increment exactly 32·PRESCALE·STEP_FRAMES clocks later.
